// File: rtl/pc_fetch_reg.sv
// pc_fetch_reg: program-counter register and fetch sequencer for the
// unpipelined core. Holds the fetch address, drives the instruction-memory
// request/ready handshake, parks a branch redirect while a fetch is
// outstanding and stops the core on halt.
// Optional feature macro: PC_ALIGN_CHECK_EN (adds align_err; odd branch
// targets halt the core). Without it, br_target[0] is forced to 0.
module pc_fetch_reg #(
    parameter int               WIDTH    = 16,
    parameter logic [WIDTH-1:0] RESET_PC = '0,
    parameter int               INC      = 2
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             stall,
    input  logic             halt,
    input  logic             br_taken,
    input  logic [WIDTH-1:0] br_target,
    input  logic             imem_rdy,
    output logic             imem_req,
    output logic [WIDTH-1:0] pc,
    output logic [WIDTH-1:0] pc_plus,
    output logic             fetch_valid,
    output logic             halted
`ifdef PC_ALIGN_CHECK_EN
    ,
    output logic             align_err
`endif
);

    typedef enum logic [1:0] {
        BOOT = 2'd0,
        RUN  = 2'd1,
        WAIT = 2'd2,
        HALT = 2'd3
    } state_t;

    localparam logic [WIDTH-1:0] INC_W = WIDTH'(INC);
    localparam logic [WIDTH-1:0] LSB_W = WIDTH'(1);

    state_t           state;
    logic             redir_vld;
    logic [WIDTH-1:0] redir_pc;
    logic [WIDTH-1:0] tgt;
    logic             tgt_bad;
    logic [WIDTH-1:0] seq_pc;

`ifdef PC_ALIGN_CHECK_EN
    assign tgt     = br_target;
    assign tgt_bad = br_target[0];
`else
    // Odd targets are silently aligned so pc[0] can never become 1.
    assign tgt     = br_target & ~LSB_W;
    assign tgt_bad = 1'b0;
`endif

    // Sequential successor wraps modulo 2^WIDTH with no carry flag.
    assign pc_plus = pc + INC_W;
    // A parked redirect overrides the sequential successor on completion.
    assign seq_pc  = redir_vld ? redir_pc : pc_plus;

    // Fetched word is usable only if it was not squashed by a redirect and
    // (in RUN) downstream is not stalling; WAIT ignores stall.
    always_comb begin
        fetch_valid = 1'b0;
        case (state)
            RUN:     fetch_valid = imem_rdy & ~redir_vld & ~stall;
            WAIT:    fetch_valid = imem_rdy & ~redir_vld;
            default: fetch_valid = 1'b0;
        endcase
    end

    // Fetch FSM: state, pc, redirect buffer and registered status outputs.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state     <= BOOT;
            pc        <= RESET_PC;
            redir_vld <= 1'b0;
            redir_pc  <= '0;
            imem_req  <= 1'b0;
            halted    <= 1'b0;
`ifdef PC_ALIGN_CHECK_EN
            align_err <= 1'b0;
`endif
        end else begin
            case (state)
                BOOT: begin
                    state    <= RUN;
                    imem_req <= 1'b1;
                end
                RUN: begin
                    if (halt || (br_taken && tgt_bad)) begin
                        // Halt wins over everything; a coincident branch is dropped.
                        state    <= HALT;
                        imem_req <= 1'b0;
                        halted   <= 1'b1;
`ifdef PC_ALIGN_CHECK_EN
                        if (!halt) align_err <= 1'b1;
`endif
                    end else if (br_taken) begin
                        if (imem_rdy) begin
                            pc        <= tgt;
                            redir_vld <= 1'b0;
                        end else begin
                            // Fetch still outstanding: park the target.
                            redir_pc  <= tgt;
                            redir_vld <= 1'b1;
                            state     <= WAIT;
                        end
                    end else if (stall) begin
                        state <= RUN;
                    end else if (imem_rdy) begin
                        pc        <= seq_pc;
                        redir_vld <= 1'b0;
                    end else begin
                        state <= WAIT;
                    end
                end
                WAIT: begin
                    if (halt || (br_taken && tgt_bad)) begin
                        state    <= HALT;
                        imem_req <= 1'b0;
                        halted   <= 1'b1;
`ifdef PC_ALIGN_CHECK_EN
                        if (!halt) align_err <= 1'b1;
`endif
                    end else if (imem_rdy) begin
                        // Completion; a same-cycle branch is the latest redirect.
                        state     <= RUN;
                        pc        <= br_taken ? tgt : seq_pc;
                        redir_vld <= 1'b0;
                    end else if (br_taken) begin
                        redir_pc  <= tgt;
                        redir_vld <= 1'b1;
                    end
                end
                default: begin
                    state <= HALT;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_pc_fetch_reg.sv
// tb_pc_fetch_reg: scoreboard bench for pc_fetch_reg. Driver applies
// directed then random stimulus on the falling edge and pushes the
// reference model's prediction; a monitor pops and compares.
module tb_pc_fetch_reg;

    logic        clk = 1'b0;
    logic        rst_n, stall, halt, br_taken, imem_rdy;
    logic [15:0] br_target;
    logic        imem_req, fetch_valid, halted;
    logic [15:0] pc, pc_plus;
`ifdef PC_ALIGN_CHECK_EN
    logic        align_err;
`endif

    always #5 clk = ~clk;

    pc_fetch_reg #(.WIDTH(16), .RESET_PC(16'h0000), .INC(2)) dut (
        .clk(clk), .rst_n(rst_n), .stall(stall), .halt(halt),
        .br_taken(br_taken), .br_target(br_target), .imem_rdy(imem_rdy),
        .imem_req(imem_req), .pc(pc), .pc_plus(pc_plus),
        .fetch_valid(fetch_valid), .halted(halted)
`ifdef PC_ALIGN_CHECK_EN
        , .align_err(align_err)
`endif
    );

    typedef struct {
        logic [15:0] pc;
        logic [15:0] plus;
        logic        req;
        logic        fv;
        logic        hlt;
        logic        aerr;
    } exp_t;

    exp_t q[$];
    int   vectors = 0;
    int   miscompares = 0;
    bit   drv_done = 0;

    // Reference model: spec-level state of the fetch unit.
    string       m_mode;   // "boot", "run", "wait", "halt"
    int unsigned m_pc;
    int unsigned m_rp;
    bit          m_rv;
    bit          m_aerr;

    function automatic void model_reset();
        m_mode = "boot"; m_pc = 0; m_rp = 0; m_rv = 0; m_aerr = 0;
    endfunction

    function automatic void model_halt(input bit align);
        m_mode = "halt";
        if (align) m_aerr = 1;
    endfunction

    // One clock of stimulus: set inputs, predict this cycle's outputs,
    // then advance the model across the coming rising edge.
    task automatic step(input bit r, input bit s, input bit h, input bit b,
                        input logic [15:0] t, input bit d);
        exp_t        e;
        bit          odd;
        int unsigned tt;
        rst_n = r; stall = s; halt = h; br_taken = b; br_target = t; imem_rdy = d;
        e.pc   = 16'(m_pc);
        e.plus = 16'((m_pc + 2) % 65536);
        e.req  = (m_mode == "run" || m_mode == "wait");
        e.hlt  = (m_mode == "halt");
        e.fv   = (m_mode == "run"  && d && !m_rv && !s) ||
                 (m_mode == "wait" && d && !m_rv);
        e.aerr = m_aerr;
        q.push_back(e);
`ifdef PC_ALIGN_CHECK_EN
        odd = b && t[0];
        tt  = t;
`else
        odd = 0;
        tt  = t - (t % 2);
`endif
        if (!r) model_reset();
        else if (m_mode == "boot") m_mode = "run";
        else if (m_mode == "run") begin
            if (h) model_halt(0);
            else if (odd) model_halt(1);
            else if (b) begin
                if (d) begin m_pc = tt; m_rv = 0; end
                else begin m_rp = tt; m_rv = 1; m_mode = "wait"; end
            end else if (s) begin
                // held
            end else if (d) begin
                m_pc = m_rv ? m_rp : (m_pc + 2) % 65536; m_rv = 0;
            end else m_mode = "wait";
        end else if (m_mode == "wait") begin
            if (h) model_halt(0);
            else if (odd) model_halt(1);
            else begin
                if (b) begin m_rp = tt; m_rv = 1; end
                if (d) begin
                    m_pc = m_rv ? m_rp : (m_pc + 2) % 65536;
                    m_rv = 0; m_mode = "run";
                end
            end
        end
        @(negedge clk);
    endtask

    // Monitor: compare every presented cycle against the oldest prediction.
    initial begin
        exp_t e;
        bit   aerr_act;
        forever begin
            @(negedge clk);
            #2;
            if (q.size() > 0) begin
                e = q.pop_front();
`ifdef PC_ALIGN_CHECK_EN
                aerr_act = align_err;
`else
                aerr_act = 1'b0;
`endif
                vectors++;
                if (pc !== e.pc || pc_plus !== e.plus || imem_req !== e.req ||
                    fetch_valid !== e.fv || halted !== e.hlt || aerr_act !== e.aerr) begin
                    miscompares++;
                    $display("FAIL vec%0d: got pc=%h plus=%h req=%b fv=%b hlt=%b aerr=%b, want pc=%h plus=%h req=%b fv=%b hlt=%b aerr=%b",
                             vectors, pc, pc_plus, imem_req, fetch_valid, halted, aerr_act,
                             e.pc, e.plus, e.req, e.fv, e.hlt, e.aerr);
                end
            end
        end
    end

    // Watchdog so the run always ends.
    initial begin
        #2000000;
        $display("FAIL timeout: drv_done=%0d, want 1", drv_done);
        $fatal(1, "timeout");
    end

    initial begin
        rst_n = 0; stall = 0; halt = 0; br_taken = 0; br_target = 0; imem_rdy = 0;
        model_reset();
        @(negedge clk);
        // 1: reset then constant ready
        step(0, 0, 0, 0, 16'h0, 1);
        repeat (5) step(1, 0, 0, 0, 16'h0, 1);
        // 2: taken branch with ready
        step(1, 0, 0, 1, 16'h0010, 1);
        step(1, 0, 0, 1, 16'h0040, 1);
        step(1, 0, 0, 0, 16'h0, 1);
        step(1, 0, 0, 0, 16'h0, 1);
        // 3: redirect while waiting, completion squashed
        step(1, 0, 0, 1, 16'h0020, 1);
        step(1, 0, 0, 0, 16'h0, 0);
        step(1, 0, 0, 1, 16'h0080, 0);
        step(1, 0, 0, 0, 16'h0, 0);
        step(1, 0, 0, 0, 16'h0, 1);
        step(1, 0, 0, 0, 16'h0, 1);
        // last redirect wins; stall in WAIT ignored
        step(1, 0, 0, 0, 16'h0, 0);
        step(1, 0, 0, 1, 16'h0100, 0);
        step(1, 1, 0, 1, 16'h0200, 0);
        step(1, 1, 0, 0, 16'h0, 1);
        // br_taken with stall: redirect taken; plain stall holds pc
        step(1, 1, 0, 1, 16'h0300, 1);
        step(1, 1, 0, 0, 16'h0, 1);
        step(1, 0, 0, 0, 16'h0, 1);
        // 4: wrap-around
        step(1, 0, 0, 1, 16'hFFFE, 1);
        step(1, 0, 0, 0, 16'h0, 1);
        step(1, 0, 0, 0, 16'h0, 1);
        // 5: halt with branch, inputs ignored, reset exits
        step(1, 0, 0, 1, 16'h0030, 1);
        step(1, 0, 1, 1, 16'h0100, 1);
        step(1, 1, 0, 1, 16'h0200, 1);
        step(1, 0, 0, 0, 16'h0, 1);
        step(0, 0, 0, 0, 16'h0, 1);
        step(1, 0, 0, 0, 16'h0, 1);
        step(1, 0, 0, 0, 16'h0, 1);
        // 6: odd target
        step(1, 0, 0, 1, 16'h0041, 1);
        step(1, 0, 0, 0, 16'h0, 1);
        step(1, 0, 0, 1, 16'h0063, 0);
        step(1, 0, 0, 0, 16'h0, 1);
        step(0, 0, 0, 0, 16'h0, 0);
        // random phase
        for (int i = 0; i < 3000; i++) begin
            logic [15:0] t;
            t = 16'($urandom);
            if ($urandom_range(0, 9) == 0) t = 16'hFFFE;
            step($urandom_range(0, 199) != 0,
                 $urandom_range(0, 3) == 0,
                 $urandom_range(0, 99) == 0,
                 $urandom_range(0, 4) == 0,
                 t,
                 $urandom_range(0, 2) != 0);
        end
        drv_done = 1;
        @(negedge clk);
        #4;
        if (q.size() != 0) begin
            miscompares++;
            $display("FAIL drain: %0d predictions left, want 0", q.size());
        end
        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule
